eth_sb_axi_sub: RTL

Subordinate (responder) end of the sideband AXI request/response interface driven by the sbeth initiator FSM. It accepts one read or write request at a time and decodes the address against a local window. It executes the access on a single-port local memory/register backend with grant/rvalid handshakes, then returns a response code and read data. It sits on the subordinate side of the D2D sideband path, in front of the local register SRAM.

---
 rtl/eth_sb_axi_pkg.sv | 21 ++
 rtl/eth_sb_timeout_cnt.sv | 51 +++++
 rtl/eth_sb_axi_sub.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_sb_axi_pkg.sv
// Shared definitions for the sideband AXI request/response path.
// Holds the response codes used by both the initiator FSM and the
// subordinate, and the subordinate FSM state type.
//   bit0 = write, bit1 = decode error, bit2 = slave error
package eth_sb_axi_pkg;

    localparam logic [2:0] RESP_OK_R     = 3'b000;
    localparam logic [2:0] RESP_OK_W     = 3'b001;
    localparam logic [2:0] RESP_DECERR_R = 3'b010;
    localparam logic [2:0] RESP_DECERR_W = 3'b011;
    localparam logic [2:0] RESP_SLVERR_R = 3'b100;
    localparam logic [2:0] RESP_SLVERR_W = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } sb_state_e;

endpackage

// File: rtl/eth_sb_timeout_cnt.sv
// Backend access timeout counter.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_clr            : restart the count at zero (priority over i_en)
//   i_en             : count one cycle of an outstanding access
//   o_expired        : registered flag, high while the count equals TIMEOUT-1
// The count saturates at TIMEOUT-1 so the flag cannot wrap away if the
// access lingers after expiry (e.g. grant won the expiry cycle on a read).
module eth_sb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          expired_r;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_nxt_s = count_r;
        if (i_clr) begin
            count_nxt_s = {CW{1'b0}};
        end else if (i_en && (count_r != CNT_MAX)) begin
            count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and expiry flag registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_r   <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            expired_r <= (count_nxt_s == CNT_MAX);
        end
    end

    assign o_expired = expired_r;

endmodule

// File: rtl/eth_sb_axi_sub.sv
// Sideband AXI subordinate: accepts one read/write request at a time from
// the sbeth initiator, decodes it against the local window and runs it on a
// single-port register SRAM backend with gnt/rvalid handshakes.
// Ports:
//   i_clk, i_reset_n         : clock, async active-low reset
//   i_axi_m*                 : request from initiator (read/write/addr/data/strobe/ready)
//   o_axi_saccept            : one-cycle accept pulse
//   o_axi_svalid/sresp/sdata : response, held until i_axi_mready
//   o_mem_*                  : backend request, held until i_mem_gnt
//   i_mem_gnt/rvalid/rdata/err : backend handshake and result
module eth_sb_axi_sub
    import eth_sb_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 24'h10_0000,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_axi_mread,
    input  logic                  i_axi_mwrite,
    input  logic [ADDR_WIDTH-1:0] i_axi_maddr,
    input  logic [DATA_WIDTH-1:0] i_axi_mdata,
    input  logic [3:0]            i_axi_mwstrb,
    input  logic                  i_axi_mready,
    output logic                  o_axi_saccept,
    output logic                  o_axi_svalid,
    output logic [2:0]            o_axi_sresp,
    output logic [DATA_WIDTH-1:0] o_axi_sdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DEPTH_LOG2-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_err
);

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    sb_state_e             state_r,    state_nxt_s;
    logic                  saccept_r,  saccept_nxt_s;
    logic                  svalid_r,   svalid_nxt_s;
    logic [2:0]            sresp_r,    sresp_nxt_s;
    logic [DATA_WIDTH-1:0] sdata_r,    sdata_nxt_s;
    logic                  mem_req_r,  mem_req_nxt_s;
    logic                  mem_we_r,   mem_we_nxt_s;
    logic [DEPTH_LOG2-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [3:0]            mem_be_r,   mem_be_nxt_s;

    logic cnt_clr_s;
    logic cnt_en_s;
    logic cnt_expired_s;
    logic req_s;
    logic win_hit_s;

    assign req_s     = i_axi_mread | i_axi_mwrite;
    assign win_hit_s = (i_axi_maddr[ADDR_WIDTH-1:DEPTH_LOG2+2] ==
                        BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+2]);

    eth_sb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (cnt_clr_s),
        .i_en      (cnt_en_s),
        .o_expired (cnt_expired_s)
    );

    // Next-state and next-output logic; all outputs hold unless changed.
    always_comb begin
        state_nxt_s     = state_r;
        saccept_nxt_s   = 1'b0;
        svalid_nxt_s    = svalid_r;
        sresp_nxt_s     = sresp_r;
        sdata_nxt_s     = sdata_r;
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        mem_be_nxt_s    = mem_be_r;
        cnt_clr_s       = 1'b0;
        cnt_en_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    saccept_nxt_s   = 1'b1;
                    mem_we_nxt_s    = i_axi_mwrite;
                    mem_addr_nxt_s  = i_axi_maddr[DEPTH_LOG2+1:2];
                    mem_wdata_nxt_s = i_axi_mdata;
                    mem_be_nxt_s    = i_axi_mwstrb;
                    sdata_nxt_s     = DATA_ZERO;
                    if (i_axi_mread && i_axi_mwrite) begin
                        // Conflicting request is reported as a write error.
                        svalid_nxt_s = 1'b1;
                        sresp_nxt_s  = RESP_SLVERR_W;
                        state_nxt_s  = ST_RESP;
                    end else if (i_axi_maddr[1:0] != 2'b00) begin
                        svalid_nxt_s = 1'b1;
                        sresp_nxt_s  = i_axi_mwrite ? RESP_SLVERR_W : RESP_SLVERR_R;
                        state_nxt_s  = ST_RESP;
                    end else if (!win_hit_s) begin
                        svalid_nxt_s = 1'b1;
                        sresp_nxt_s  = i_axi_mwrite ? RESP_DECERR_W : RESP_DECERR_R;
                        state_nxt_s  = ST_RESP;
                    end else if (i_axi_mwrite && (i_axi_mwstrb == 4'b0000)) begin
                        // Nothing to write: acknowledge without touching the backend.
                        svalid_nxt_s = 1'b1;
                        sresp_nxt_s  = RESP_OK_W;
                        state_nxt_s  = ST_RESP;
                    end else begin
                        mem_req_nxt_s = 1'b1;
                        cnt_clr_s     = 1'b1;
                        state_nxt_s   = ST_MEM_REQ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_MEM_REQ: begin
                cnt_en_s = 1'b1;
                if (i_mem_gnt) begin
                    // Grant beats a coincident timeout expiry.
                    mem_req_nxt_s = 1'b0;
                    if (mem_we_r) begin
                        svalid_nxt_s = 1'b1;
                        sresp_nxt_s  = i_mem_err ? RESP_SLVERR_W : RESP_OK_W;
                        sdata_nxt_s  = DATA_ZERO;
                        state_nxt_s  = ST_RESP;
                    end else begin
                        state_nxt_s = ST_MEM_WAIT;
                    end
                end else if (cnt_expired_s) begin
                    mem_req_nxt_s = 1'b0;
                    svalid_nxt_s  = 1'b1;
                    sresp_nxt_s   = mem_we_r ? RESP_SLVERR_W : RESP_SLVERR_R;
                    sdata_nxt_s   = DATA_ZERO;
                    state_nxt_s   = ST_RESP;
                end else begin
                    state_nxt_s = ST_MEM_REQ;
                end
            end

            ST_MEM_WAIT: begin
                cnt_en_s = 1'b1;
                if (i_mem_rvalid) begin
                    // Read data beats a coincident timeout expiry.
                    svalid_nxt_s = 1'b1;
                    sresp_nxt_s  = i_mem_err ? RESP_SLVERR_R : RESP_OK_R;
                    sdata_nxt_s  = i_mem_err ? DATA_ZERO : i_mem_rdata;
                    state_nxt_s  = ST_RESP;
                end else if (cnt_expired_s) begin
                    svalid_nxt_s = 1'b1;
                    sresp_nxt_s  = RESP_SLVERR_R;
                    sdata_nxt_s  = DATA_ZERO;
                    state_nxt_s  = ST_RESP;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end

            ST_RESP: begin
                if (i_axi_mready) begin
                    svalid_nxt_s = 1'b0;
                    sresp_nxt_s  = RESP_OK_R;
                    sdata_nxt_s  = DATA_ZERO;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end

            default: begin
                state_nxt_s   = ST_IDLE;
                svalid_nxt_s  = 1'b0;
                sresp_nxt_s   = RESP_OK_R;
                sdata_nxt_s   = DATA_ZERO;
                mem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access silently.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            saccept_r   <= 1'b0;
            svalid_r    <= 1'b0;
            sresp_r     <= 3'b000;
            sdata_r     <= DATA_ZERO;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {DEPTH_LOG2{1'b0}};
            mem_wdata_r <= DATA_ZERO;
            mem_be_r    <= 4'b0000;
        end else begin
            state_r     <= state_nxt_s;
            saccept_r   <= saccept_nxt_s;
            svalid_r    <= svalid_nxt_s;
            sresp_r     <= sresp_nxt_s;
            sdata_r     <= sdata_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            mem_be_r    <= mem_be_nxt_s;
        end
    end

    assign o_axi_saccept = saccept_r;
    assign o_axi_svalid  = svalid_r;
    assign o_axi_sresp   = sresp_r;
    assign o_axi_sdata   = sdata_r;
    assign o_mem_req     = mem_req_r;
    assign o_mem_we      = mem_we_r;
    assign o_mem_addr    = mem_addr_r;
    assign o_mem_wdata   = mem_wdata_r;
    assign o_mem_be      = mem_be_r;

endmodule
